// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller and
// the pipeline-register wrappers that consume its stage controls.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_flush;
    logic freeze;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};
  localparam stage_ctrl_t CTRL_STALL  = '{idex_bubble: 1'b1, default: 1'b0};
  localparam stage_ctrl_t CTRL_FREEZE = '{freeze: 1'b1, default: 1'b0};
  localparam stage_ctrl_t CTRL_FLUSH  = '{freeze: 1'b0, default: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, branch squash and memory-wait freeze sequencing for the
// IF/ID and ID/EX registers, with saturating debug counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [4:0]       id_rd,
  input  logic             id_mem_read,
  input  logic             id_reg_write,
  input  logic             branch_taken,
  input  logic             mem_wait,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout,
  output state_e           dbg_state
);

  // Handshake: no valid/ready pairs here; every control is a level that the
  // pipeline registers sample on the same rising edge it is decoded for.

  localparam int WCW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(WAIT_TIMEOUT);

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic        ex_valid_q, ex_mem_read_q;
  logic [4:0]  ex_rd_q;
  logic [WCW-1:0] wait_ctr_q, wait_ctr_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic        hazard, do_stall, do_flush;
  stage_ctrl_t ctrl;

  assign hazard = ex_valid_q && ex_mem_read_q && id_valid && (ex_rd_q != XZR_IDX) &&
                  ((id_uses_rn && (id_rn == ex_rd_q)) || (id_uses_rm && (id_rm == ex_rd_q)));

  // Reset gates the decode so the outputs read as free-running while RESET is low.
  always_comb begin
    ctrl     = CTRL_RUN;
    do_stall = 1'b0;
    do_flush = 1'b0;
    state_d  = state_q;
    pend_d   = pend_q;
    if (RESET) begin
      case (state_q)
        ST_RUN: begin
          if (mem_wait) begin
            ctrl    = CTRL_FREEZE;
            state_d = ST_FREEZE;
            pend_d  = branch_taken;
          end else if (branch_taken) begin
            ctrl     = CTRL_FLUSH;
            do_flush = 1'b1;
          end else if (hazard) begin
            ctrl     = CTRL_STALL;
            do_stall = 1'b1;
          end
        end
        ST_FREEZE: begin
          ctrl   = CTRL_FREEZE;
          pend_d = pend_q | branch_taken;
          if (!mem_wait) begin
            state_d = (pend_q | branch_taken) ? ST_FLUSH : ST_RUN;
          end
        end
        ST_FLUSH: begin
          ctrl     = CTRL_FLUSH;
          do_flush = 1'b1;
          pend_d   = 1'b0;
          state_d  = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    wait_ctr_d = '0;
    if (mem_wait) begin
      wait_ctr_d = (wait_ctr_q == WAIT_MAX) ? wait_ctr_q : wait_ctr_q + 1'b1;
    end
    mem_timeout_d = mem_timeout_q | (wait_ctr_d == WAIT_MAX);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_RUN;
      pend_q        <= 1'b0;
      ex_valid_q    <= 1'b0;
      ex_rd_q       <= 5'd0;
      ex_mem_read_q <= 1'b0;
      wait_ctr_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      wait_ctr_q    <= wait_ctr_d;
      mem_timeout_q <= mem_timeout_d;
      // EX shadow mirrors what the ID/EX register captures on this edge.
      if (!ctrl.freeze) begin
        if (ctrl.idex_bubble) begin
          ex_valid_q <= 1'b0;
        end else begin
          ex_valid_q    <= id_valid & id_reg_write;
          ex_rd_q       <= id_rd;
          ex_mem_read_q <= id_mem_read;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (CLK),
    .rst_ni(RESET),
    .inc   (do_stall),
    .clr   (1'b0),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (CLK),
    .rst_ni(RESET),
    .inc   (do_flush),
    .clr   (1'b0),
    .cnt_o (flush_cnt)
  );

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign exmem_flush = ctrl.exmem_flush;
  assign freeze      = ctrl.freeze;
  assign mem_timeout = mem_timeout_q;
  assign dbg_state   = state_q;

endmodule
